// File: rtl/fb_pkg.sv
// fb_pkg: shared geometry constants and FSM state encoding for the framebuffer scan controller
package fb_pkg;
  localparam int FB_XSIZE = 128;
  localparam int FB_YSIZE = 64;
  localparam int FB_DW = 8;
  localparam int FB_ADDR_DEPTH = FB_XSIZE * FB_YSIZE / 8;
  localparam int FB_AW = $clog2(FB_ADDR_DEPTH);
  localparam int FB_PAGES = FB_YSIZE / 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, CLEAR = ST_CLEAR, SCAN = ST_SCAN} state_e;
endpackage

// File: rtl/fb_scan_fifo.sv
// fb_scan_fifo: 2-entry output FIFO holding scanout bytes with their sol/last tags
module fb_scan_fifo #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [2];
  logic r_wp, r_rp;
  logic [1:0] r_cnt;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wp] <= i_data;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_wp <= 1'b0;
      r_rp <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) r_wp <= ~r_wp;
      if (i_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  assign o_data = r_mem[r_rp];
  assign o_valid = r_cnt != 2'd0;
  assign o_count = r_cnt;
endmodule

// File: rtl/fb_scan_ctrl.sv
// fb_scan_ctrl: framebuffer write arbitration, clear engine and full-frame scanout byte stream
module fb_scan_ctrl
  import fb_pkg::*;
#(
  parameter int XSIZE = FB_XSIZE,
  parameter int YSIZE = FB_YSIZE,
  parameter int DATA_WIDTH = FB_DW,
  localparam int ADDR_DEPTH = XSIZE * YSIZE / 8,
  localparam int AW = $clog2(ADDR_DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start_frame,
  input  logic                  clear_req,
  input  logic [DATA_WIDTH-1:0] clear_pattern,
  output logic                  busy,
  output logic                  frame_done,
  input  logic                  cl_wr_valid,
  output logic                  cl_wr_ready,
  input  logic [AW-1:0]         cl_wr_addr,
  input  logic [DATA_WIDTH-1:0] cl_wr_data,
  output logic                  fb_cs,
  output logic                  fb_we,
  output logic [AW-1:0]         fb_wr_addr,
  output logic [AW-1:0]         fb_rd_addr,
  output logic [DATA_WIDTH-1:0] fb_in,
  input  logic [DATA_WIDTH-1:0] fb_out,
  output logic                  px_valid,
  input  logic                  px_ready,
  output logic [DATA_WIDTH-1:0] px_data,
  output logic                  px_sol,
  output logic                  px_last
);
  state_e r_state;
  logic r_cs, r_clr_pend, r_start_pend, r_inf, r_inf_sol, r_inf_last, r_rd_done;
  logic [AW-1:0] r_clr_addr, r_rd_addr;
  logic [DATA_WIDTH-1:0] r_pattern, r_pend_pat;
  logic w_clr, w_start, w_issue, w_pop, w_cl_acc, w_clr_last, w_sol, w_last;
  logic [DATA_WIDTH-1:0] w_pat;
  logic [1:0] w_cnt;
  logic [DATA_WIDTH+1:0] w_head;
  assign w_clr = clear_req | r_clr_pend;
  assign w_start = start_frame | r_start_pend;
  assign w_pat = r_clr_pend ? r_pend_pat : clear_pattern;
  assign w_clr_last = r_clr_addr == AW'(ADDR_DEPTH - 1);
  assign w_sol = (int'(r_rd_addr) % XSIZE) == 0;
  assign w_last = r_rd_addr == AW'(ADDR_DEPTH - 1);
  assign w_pop = px_valid & px_ready;
  // the byte leaving this cycle frees its slot, which keeps reads flowing at one per clock
  assign w_issue = r_state == SCAN && !r_rd_done &&
                   ({1'b0, w_cnt} - {2'b0, w_pop} + {2'b0, r_inf}) < 3'd2;
  assign busy = r_state != IDLE;
  assign cl_wr_ready = r_cs && r_state != CLEAR;
  assign w_cl_acc = cl_wr_valid & cl_wr_ready;
  assign fb_cs = r_cs;
  assign fb_we = r_state == CLEAR || w_cl_acc;
  assign fb_wr_addr = r_state == CLEAR ? r_clr_addr : cl_wr_addr;
  assign fb_in = r_state == CLEAR ? r_pattern : cl_wr_data;
  assign fb_rd_addr = r_rd_addr;
  assign frame_done = w_pop & px_last;
  assign {px_data, px_sol, px_last} = w_head;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state <= IDLE;
      r_cs <= 1'b0;
      r_clr_pend <= 1'b0;
      r_start_pend <= 1'b0;
      r_inf <= 1'b0;
      r_inf_sol <= 1'b0;
      r_inf_last <= 1'b0;
      r_rd_done <= 1'b0;
      r_clr_addr <= '0;
      r_rd_addr <= '0;
      r_pattern <= '0;
      r_pend_pat <= '0;
    end else begin
      r_cs <= 1'b1;
      r_inf <= w_issue;
      if (w_issue) begin
        r_rd_addr <= r_rd_addr + 1'b1;
        r_rd_done <= w_last;
        r_inf_sol <= w_sol;
        r_inf_last <= w_last;
      end
      if (clear_req && !r_clr_pend) r_pend_pat <= clear_pattern;
      r_clr_pend <= w_clr;
      r_start_pend <= w_start;
      case (r_state)
        IDLE:
          if (w_clr) begin
            r_state <= CLEAR;
            r_clr_pend <= 1'b0;
            r_pattern <= w_pat;
            r_clr_addr <= '0;
          end else if (w_start) begin
            r_state <= SCAN;
            r_start_pend <= 1'b0;
            r_rd_done <= 1'b0;
          end
        CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (w_clr_last) r_state <= IDLE;
        end
        SCAN: if (frame_done) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  fb_scan_fifo #(.W(DATA_WIDTH + 2)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .i_push(r_inf),
    .i_data({fb_out, r_inf_sol, r_inf_last}),
    .i_pop(w_pop),
    .o_data(w_head),
    .o_valid(px_valid),
    .o_count(w_cnt)
  );
endmodule

// File: tb/tb_fb_scan_ctrl.sv
// tb_fb_scan_ctrl: directed bench with a framebuffer memory model and an expected-byte scoreboard
module tb_fb_scan_ctrl;
  localparam int XS = 128, YS = 64, DEPTH = XS * YS / 8, AW = $clog2(DEPTH);
  logic clk = 0, resetn = 0, start_frame = 0, clear_req = 0, cl_wr_valid = 0, px_ready = 1;
  logic [7:0] clear_pattern = 0, cl_wr_data = 0, fb_in, px_data, fb_q;
  logic [AW-1:0] cl_wr_addr = 0, fb_wr_addr, fb_rd_addr;
  wire [7:0] fb_out;
  logic busy, frame_done, cl_wr_ready, fb_cs, fb_we, px_valid, px_sol, px_last;
  logic [7:0] fb_mem [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  logic [9:0] exp_q [$];
  logic [9:0] prev;
  int pass_cnt = 0, total = 0, hs_cnt = 0, sol_cnt = 0, last_cnt = 0, fd_cnt = 0, stall_cnt = 0;
  bit rand_rdy = 0, stall_prev = 0;

  always #5 clk = ~clk;

  fb_scan_ctrl dut (
    .clk(clk), .resetn(resetn), .start_frame(start_frame), .clear_req(clear_req),
    .clear_pattern(clear_pattern), .busy(busy), .frame_done(frame_done),
    .cl_wr_valid(cl_wr_valid), .cl_wr_ready(cl_wr_ready), .cl_wr_addr(cl_wr_addr),
    .cl_wr_data(cl_wr_data), .fb_cs(fb_cs), .fb_we(fb_we), .fb_wr_addr(fb_wr_addr),
    .fb_rd_addr(fb_rd_addr), .fb_in(fb_in), .fb_out(fb_out), .px_valid(px_valid),
    .px_ready(px_ready), .px_data(px_data), .px_sol(px_sol), .px_last(px_last)
  );

  // framebuffer: registered read returning old data on same-address write, tri-stated when deselected
  always @(posedge clk) if (fb_cs) begin
    fb_q <= fb_mem[fb_rd_addr];
    if (fb_we) fb_mem[fb_wr_addr] <= fb_in;
  end
  assign fb_out = fb_cs ? fb_q : 'z;

  always @(posedge clk) #1 px_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    bit hs;
    hs = resetn && px_valid && px_ready;
    e = '0;
    if (hs) begin
      check("byte expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("px byte", {px_data, px_sol, px_last}, e);
      end
      hs_cnt++;
      sol_cnt += px_sol;
      last_cnt += px_last;
    end
    if (resetn) begin
      check("frame_done", frame_done, hs && e[0]);
      if (stall_prev) check("stall hold", {px_valid, px_data, px_sol, px_last}, {1'b1, prev});
    end
    fd_cnt += frame_done;
    stall_prev = resetn && px_valid && !px_ready;
    stall_cnt += stall_prev;
    prev = {px_data, px_sol, px_last};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({ref_mem[i], i % XS == 0, i == DEPTH - 1});
  endtask

  task automatic pulse_start();
    start_frame = 1;
    tick();
    start_frame = 0;
  endtask

  task automatic do_clear(input logic [7:0] pat, output int nbusy);
    int bad = 0;
    clear_pattern = pat;
    clear_req = 1;
    tick();
    clear_req = 0;
    clear_pattern = ~pat;
    nbusy = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy) break;
      nbusy++;
      if (cl_wr_ready) bad++;
    end
    check("ready low in clear", bad, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat;
    tick();
  endtask

  task automatic cl_write(input logic [AW-1:0] a, input logic [7:0] d);
    int w = 0;
    cl_wr_valid = 1;
    cl_wr_addr = a;
    cl_wr_data = d;
    @(negedge clk);
    while (!cl_wr_ready && w < 3000) begin w++; @(negedge clk); end
    check("client write accepted", cl_wr_ready, 1);
    tick();
    ref_mem[a] = d;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (fd_cnt < target && n < budget) begin @(negedge clk); #1; n++; end
    check("frame_done within budget", fd_cnt >= target, 1);
    repeat (20) tick();
    check("frame count", fd_cnt, target);
    check("idle after frames", busy, 0);
    check("scoreboard drained", exp_q.size(), 0);
  endtask

  initial begin
    int n, lat, run, h0;
    cl_wr_valid = 1;
    cl_wr_addr = 7;
    cl_wr_data = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst frame_done", frame_done, 0);
    check("rst px_valid", px_valid, 0);
    check("rst fb_we", fb_we, 0);
    check("rst fb_cs", fb_cs, 0);
    check("rst fb_rd_addr", fb_rd_addr, 0);
    check("rst cl_wr_ready", cl_wr_ready, 0);
    cl_wr_valid = 0;
    resetn = 1;
    tick();
    check("cs after reset", fb_cs, 1);
    check("ready in idle", cl_wr_ready, 1);

    // clear to A5 then stream it back
    do_clear(8'hA5, n);
    check("clear busy cycles", n, 1024);
    fd_cnt = 0;
    push_frame();
    pulse_start();
    wait_frames(1, 1500);

    // ramp pattern, full-rate stream
    for (int i = 0; i < DEPTH; i++) cl_write(i[AW-1:0], i[7:0]);
    cl_wr_valid = 0;
    tick();
    sol_cnt = 0;
    last_cnt = 0;
    fd_cnt = 0;
    push_frame();
    pulse_start();
    lat = 0;
    @(negedge clk);
    while (!px_valid && lat < 20) begin lat++; @(negedge clk); end
    check("first px_valid latency", lat, 2);
    check("first ramp byte", {px_data, px_sol, px_last}, {8'h00, 1'b1, 1'b0});
    run = 1;
    while (!frame_done && run < 3000) begin @(negedge clk); run++; end
    check("back-to-back cycles", run, 1024);
    #1;
    check("sol count", sol_cnt, 8);
    check("last count", last_cnt, 1);
    wait_frames(1, 100);

    // 50% backpressure
    fd_cnt = 0;
    stall_cnt = 0;
    rand_rdy = 1;
    push_frame();
    pulse_start();
    wait_frames(1, 6000);
    rand_rdy = 0;
    check("stalls exercised", stall_cnt > 50, 1);

    // simultaneous clear+start, then an extra start mid-scan
    fd_cnt = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    push_frame();
    clear_pattern = 8'h00;
    clear_req = 1;
    start_frame = 1;
    tick();
    clear_req = 0;
    start_frame = 0;
    clear_pattern = 8'hFF;
    check("clear wins: fb_we", fb_we, 1);
    check("clear wins: fb_in", fb_in, 8'h00);
    check("clear wins: no stream", px_valid, 0);
    h0 = hs_cnt;
    n = 0;
    while (hs_cnt < h0 + 500 && n < 6000) begin tick(); n++; end
    push_frame();
    pulse_start();
    wait_frames(2, 4000);

    // client write held during clear
    clear_pattern = 8'h11;
    clear_req = 1;
    tick();
    clear_req = 0;
    repeat (5) tick();
    cl_wr_valid = 1;
    cl_wr_addr = 5;
    cl_wr_data = 8'h3C;
    @(negedge clk);
    check("ready low during clear", cl_wr_ready, 0);
    n = 0;
    while (!cl_wr_ready && n < 3000) begin n++; @(negedge clk); end
    check("write wait cycles", n, 1019);
    check("write after clear: busy", busy, 0);
    check("write pass fb_we", fb_we, 1);
    check("write pass fb_wr_addr", fb_wr_addr, 5);
    check("write pass fb_in", fb_in, 8'h3C);
    tick();
    cl_wr_valid = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h11;
    ref_mem[5] = 8'h3C;
    fd_cnt = 0;
    push_frame();
    pulse_start();
    wait_frames(1, 1500);

    // reset at byte 300 of a scan
    fd_cnt = 0;
    h0 = hs_cnt;
    push_frame();
    pulse_start();
    n = 0;
    while (hs_cnt < h0 + 300 && n < 2000) begin tick(); n++; end
    resetn = 0;
    #1;
    check("mid-scan rst busy", busy, 0);
    check("mid-scan rst px_valid", px_valid, 0);
    check("mid-scan rst frame_done", frame_done, 0);
    check("mid-scan rst fb_cs", fb_cs, 0);
    check("mid-scan rst fb_rd_addr", fb_rd_addr, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1;
    tick();
    check("no frame_done on reset", fd_cnt, 0);
    push_frame();
    pulse_start();
    lat = 0;
    @(negedge clk);
    while (!px_valid && lat < 20) begin lat++; @(negedge clk); end
    check("restart first byte", {px_data, px_sol, px_last}, {8'h11, 1'b1, 1'b0});
    wait_frames(1, 1500);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
